prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 95 +++++++++
 tb/tb_prog_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives LEN, N data bytes and CSUM, writes the data
// bytes into program RAM from BASE_ADDR and holds the CPU off while loading or failed.
module prog_loader #(
  parameter logic [7:0] BASE_ADDR     = 8'h00,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] count_q;   // data bytes still expected; 9 bits so LEN=0 can mean 256
  logic [7:0] sum_q;
  logic [7:0] offset_q;
  logic       accept;
  logic       hold_d;

  assign busy     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign in_ready = busy;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN:  if (accept) state_d = S_DATA;
      S_DATA: if (accept && count_q == 9'd1) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
    // A failed load keeps the CPU held until a good reload.
    hold_d = (state_d == S_LEN) || (state_d == S_DATA) ||
             (state_d == S_CSUM) || (state_d == S_ERR);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      offset_q  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= BASE_ADDR;
      ram_wdata <= '0;
      cpu_hold  <= HOLD_AT_RESET;
    end else begin
      state_q  <= state_d;
      cpu_hold <= hold_d;
      ram_we   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            count_q  <= '0;
            sum_q    <= '0;
            offset_q <= '0;
          end
        end
        S_LEN: begin
          if (accept) count_q <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        end
        S_DATA: begin
          if (accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= BASE_ADDR + offset_q;
            ram_wdata <= in_data;
            sum_q     <= sum_q + in_data;
            offset_q  <= offset_q + 8'd1;
            count_q   <= count_q - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed streams plus randomized loads,
// compared cycle by cycle against a stream-level reference model.
module tb_prog_loader;

  localparam logic [7:0] BASE = 8'hFE;
  localparam bit         HOLD = 1'b1;

  localparam int M_IDLE = 0, M_LEN = 1, M_DATA = 2, M_CSUM = 3, M_DONE = 4, M_ERR = 5;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ram_we, cpu_hold, busy, done, err;
  logic [7:0] ram_addr, ram_wdata;

  prog_loader #(.BASE_ADDR(BASE), .HOLD_AT_RESET(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int we_cnt  = 0;

  // Reference model: position in the LEN/data/CSUM stream, not an RTL mirror.
  int         m_mode = M_IDLE;
  int         m_n, m_k;
  logic [7:0] m_sum;
  logic       m_acc, m_in_rst, exp_we;
  logic [7:0] exp_addr, exp_wdata;
  logic [7:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic v, input logic [7:0] d);
    logic r;
    logic hold;
    rst_n = rst; start = st; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    r      = (m_mode == M_LEN) || (m_mode == M_DATA) || (m_mode == M_CSUM);
    m_acc  = rst && v && r;
    exp_we = 1'b0;
    m_in_rst = !rst;
    if (!rst) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_ERR:
          if (st) begin m_mode = M_LEN; m_k = 0; m_sum = 8'h00; m_n = 0; end
        M_LEN:
          if (m_acc) begin m_n = (d == 8'h00) ? 256 : int'(d); m_mode = M_DATA; end
        M_DATA:
          if (m_acc) begin
            exp_we    = 1'b1;
            exp_addr  = 8'((int'(BASE) + m_k) % 256);
            exp_wdata = d;
            m_sum     = 8'((int'(m_sum) + int'(d)) % 256);
            m_k++;
            if (m_k == m_n) m_mode = M_CSUM;
          end
        M_CSUM:
          if (m_acc) m_mode = (d == m_sum) ? M_DONE : M_ERR;
        default: ;
      endcase
    end
    r    = (m_mode == M_LEN) || (m_mode == M_DATA) || (m_mode == M_CSUM);
    hold = m_in_rst ? HOLD : (r || m_mode == M_ERR);
    check("ctl{rdy,busy,done,err,hold,we}",
          {26'd0, in_ready, busy, done, err, cpu_hold, ram_we},
          {26'd0, r, r, m_mode == M_DONE, m_mode == M_ERR, hold, exp_we});
    if (ram_we === 1'b1) we_cnt++;
    if (exp_we) begin
      check("ram_addr", {24'd0, ram_addr}, {24'd0, exp_addr});
      check("ram_wdata", {24'd0, ram_wdata}, {24'd0, exp_wdata});
    end
    if (m_in_rst) begin
      check("rst_addr", {24'd0, ram_addr}, {24'd0, BASE});
      check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
    end
  endtask

  // Builds LEN, data, CSUM into q; len=256 is encoded as LEN=0.
  task automatic make_stream(input int len, input bit bad, input bit ramp);
    int s = 0;
    logic [7:0] b;
    q.delete();
    q.push_back(8'(len % 256));
    for (int i = 0; i < len; i++) begin
      b = ramp ? 8'(i) : 8'($urandom_range(255));
      s += int'(b);
      q.push_back(b);
    end
    q.push_back(bad ? 8'((s + 1 + $urandom_range(254)) % 256) : 8'(s % 256));
  endtask

  // Issues start, then feeds q; start_at >= 0 pulses start again after that many accepts.
  task automatic send_stream(input int pct, input int start_at);
    int idx = 0;
    int cyc = 0;
    logic v;
    step(1'b1, 1'b1, 1'b0, 8'($urandom_range(255)));
    while (idx < q.size() && cyc < 2000) begin
      v = ($urandom_range(99) < pct);
      step(1'b1, (idx == start_at), v, v ? q[idx] : 8'($urandom_range(255)));
      if (m_acc) idx++;
      cyc++;
    end
    check("stream_consumed", idx, q.size());
  endtask

  task automatic idle_valid(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom_range(255)));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // A1+B2+C3 = 0x216, so the good checksum is 0x16; 0x19 must fail.
    q = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    send_stream(100, -1);
    idle_valid(3);
    q = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
    send_stream(100, -1);
    idle_valid(3);

    // Full 256-byte load wrapping the address past 8'hFF; CSUM = 0x80.
    we_cnt = 0;
    make_stream(256, 1'b0, 1'b1);
    send_stream(100, -1);
    idle_valid(2);
    check("we_pulses_256", we_cnt, 256);

    // Gapped valid: LEN, gap, gap, two data bytes back to back, CSUM.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b1, 8'h96);
    idle_valid(2);

    // Reset after 2 of 4 data bytes, then a clean reload.
    q = {8'h04, 8'h11, 8'h22};
    send_stream(100, -1);
    step(1'b0, 1'b0, 1'b1, 8'h33);
    idle_valid(3);
    q = {8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_stream(100, -1);
    idle_valid(2);

    // Start pulsed mid-DATA must be ignored.
    make_stream(6, 1'b0, 1'b0);
    send_stream(100, 3);
    idle_valid(2);

    for (int n = 0; n < 25; n++) begin
      make_stream(int'($urandom_range(1, 24)), ($urandom_range(3) == 0), 1'b0);
      send_stream(int'($urandom_range(30, 100)), ($urandom_range(1) == 1) ? int'($urandom_range(0, 4)) : -1);
      idle_valid(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
